pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the five-stage core. Each cycle it decides whether the PC and IF/ID advance, whether bubbles enter the decode/execute register, and whether stage registers are flushed on a taken branch. It also freezes the whole pipeline while a memory access is outstanding and records stall and flush statistics. It sits beside the stage registers and drives their flush, nop and hold inputs.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum number of MEM_WAIT cycles without an ack before the block enters the error state.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset (`RESET_ENABLE`).
- rs1_d_i, rs2_d_i  in  5 each  source register indices of the instruction in decode.
- rs1_used_d_i, rs2_used_d_i  in  1 each  the decode instruction actually reads rs1 / rs2.
- rd_e_i  in  5  destination register index of the instruction in execute.
- RegWEn_e_i  in  1  the execute instruction writes the register file.
- load_e_i  in  1  the execute instruction is a load (write-back select = memory).
- branch_taken_e_i  in  1  execute redirects the PC (taken branch or jump).
- mem_req_m_i  in  1  the memory stage has an access pending.
- mem_ack_m_i  in  1  the memory stage access completes this cycle.
- pc_stop_o  out  1  hold the PC (`PC_STOP_ENABLE`).
- fd_stall_o  out  1  hold the IF/ID register.
- fd_flush_o  out  1  clear the IF/ID register.
- de_flush_o  out  1  drives the D/E register's pipeline_flush_i.
- de_nop_o  out  1  drives the D/E register's pipeline_nop_i (insert a bubble).
- freeze_o  out  1  hold every stage register from D/E onward.
- err_o  out  1  sticky memory-timeout error flag.
- stall_cnt_o  out  CNT_W  saturating count of cycles in which pc_stop_o=1.
- flush_cnt_o  out  CNT_W  saturating count of branch flushes.

## Operation
- Registered state: an FSM with states RUN, MEM_WAIT and ERR; a wait counter wide enough to hold MEM_TIMEOUT; the two performance counters; err_o.
- Control outputs are combinational (Mealy), computed from the current state and the current inputs.
- Load-use hazard (luh): load_e_i & RegWEn_e_i & (rd_e_i≠0) & ((rs1_used_d_i & rs1_d_i==rd_e_i) | (rs2_used_d_i & rs2_d_i==rd_e_i)).
- RUN, one priority per cycle:
  1. mem_req_m_i & !mem_ack_m_i:
     - freeze_o=1, pc_stop_o=1, fd_stall_o=1.
     - Branch and luh are not acted on this cycle.
     - Next state MEM_WAIT; wait counter loads 1.
  2. Otherwise, branch_taken_e_i:
     - fd_flush_o=1, de_flush_o=1; the PC loads the target, so pc_stop_o=0.
     - flush_cnt_o increments.
     - Wins over luh, because the dependent instruction is discarded anyway.
  3. Otherwise, luh:
     - pc_stop_o=1, fd_stall_o=1, de_nop_o=1 for this one cycle.
     - The hazard clears on its own the next cycle, once the load has moved on to memory.
  4. Otherwise all control outputs are 0.
  - mem_req_m_i together with mem_ack_m_i in the same cycle counts as a zero-wait access: no freeze, and priorities 2–4 apply.
- MEM_WAIT:
  - If mem_ack_m_i=1: freeze_o, pc_stop_o and fd_stall_o are 0 this cycle. Next state RUN. A branch or hazard is evaluated from the following cycle.
  - Else, if the wait counter equals MEM_TIMEOUT: next state ERR, err_o is set, freeze held.
  - Else: freeze, pc_stop and fd_stall stay 1; the wait counter increments.
  - Flush and nop outputs are always 0 in MEM_WAIT.
- ERR:
  - freeze_o=1, pc_stop_o=1, fd_stall_o=1 and err_o=1 permanently.
  - All inputs, including ack, are ignored. Only rst_i exits this state.
- Counters:
  - stall_cnt_o increments in every cycle where pc_stop_o=1, in all states.
  - Both counters saturate at all-ones and never wrap.

## Timing
- Reset (rst_i=1 at a clock edge): state RUN, wait counter 0, err_o=0, both counters 0.
- While rst_i=1, every control output is forced to 0.
- Hazard, branch and freeze responses take effect in the same cycle as the triggering input (zero latency). Registered effects (state, counters, err_o) appear one cycle later.
- A load-use stall costs exactly one bubble. A branch costs two squashed instructions.
- An access acked after N≥1 wait cycles freezes the pipeline for exactly N cycles.
- With MEM_TIMEOUT=16 and no ack:
  - MEM_WAIT is entered after the request cycle; err_o rises 17 cycles after the request cycle.
  - An ack arriving in the same cycle the timeout is reached still wins: the block returns to RUN and err_o is not set.
- Reset asserted in any state, including mid-wait or ERR, returns the block to the reset values at the next edge.

## Structure
- State encodings (`PLCTRL_RUN`, `PLCTRL_MEM_WAIT`, `PLCTRL_ERR`) and `PLCTRL_MEM_TIMEOUT` are added to core_param.v.
- The existing `RESET_ENABLE`, `PLFLUSH_ENABLE` and `PC_STOP_ENABLE` macros are reused for output polarities.
- Sub-module perf_sat_cnt (parameter CNT_W; inputs clk_i, rst_i, inc_i; output cnt_o, saturating) is instantiated twice, once per performance counter.
- The hazard compare stays inline.

## Test plan
- Load-use: execute is `lw x5` and decode is `add x6,x5,x7` with rs1_used=1 → pc_stop, fd_stall and de_nop are 1 for one cycle; stall_cnt_o=1.
- Load to x0: same as above but rd_e_i=0 → all control outputs 0. Non-load with rd match (load_e_i=0) → all control outputs 0.
- Branch together with a load-use hazard in the same cycle → only fd_flush_o and de_flush_o are 1, pc_stop_o=0; flush_cnt_o=1.
- mem_req held with ack after 3 cycles → freeze_o=1 for the request cycle plus 2 wait cycles, then 0 in the ack cycle; state returns to RUN. Same-cycle req+ack → no freeze.
- No ack with MEM_TIMEOUT=16 → err_o=1 at cycle 17 and stays 1; a later ack is ignored; rst_i clears err_o, the state and both counters.
- Saturation: with CNT_W=4, hold luh for 20 cycles → stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard and sequencing controller:
// FSM state encodings, the default memory timeout, and the polarities of
// the reset input and of the stall/flush control outputs.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PLCTRL_RUN      = 2'd0,
        PLCTRL_MEM_WAIT = 2'd1,
        PLCTRL_ERR      = 2'd2
    } plctrl_state_e;

    localparam int PLCTRL_MEM_TIMEOUT = 16;

    // Active level of the reset input.
    localparam logic RESET_ENABLE   = 1'b1;
    // Level that requests a flush or bubble on the stage registers.
    localparam logic PLFLUSH_ENABLE = 1'b1;
    // Level that holds the PC.
    localparam logic PC_STOP_ENABLE = 1'b1;

endpackage

// File: rtl/pipeline_ctrl_perf_sat_cnt.sv
// Saturating event counter used for the pipeline performance statistics.
// It counts cycles with inc_i high and sticks at all-ones instead of wrapping.
module perf_sat_cnt
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    // Clear on reset, otherwise advance on each event until the count is full.
    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard and sequencing controller for the five-stage core.
// Decides each cycle whether the front end stalls, whether a bubble enters
// D/E, whether a taken branch flushes IF/ID and D/E, and freezes the whole
// pipeline while a memory access is outstanding. A memory access that never
// completes leads to a sticky error state that only reset leaves.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = PLCTRL_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_d_i,
    input  logic [4:0]       rs2_d_i,
    input  logic             rs1_used_d_i,
    input  logic             rs2_used_d_i,
    input  logic [4:0]       rd_e_i,
    input  logic             RegWEn_e_i,
    input  logic             load_e_i,
    input  logic             branch_taken_e_i,
    input  logic             mem_req_m_i,
    input  logic             mem_ack_m_i,
    output logic             pc_stop_o,
    output logic             fd_stall_o,
    output logic             fd_flush_o,
    output logic             de_flush_o,
    output logic             de_nop_o,
    output logic             freeze_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    plctrl_state_e     r_state;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_err;

    plctrl_state_e     w_nextState;
    logic [WAIT_W-1:0] w_nextWait;
    logic              w_setErr;
    logic              w_reset;
    logic              w_luh;
    logic              w_pcStop;
    logic              w_fdStall;
    logic              w_fdFlush;
    logic              w_deFlush;
    logic              w_deNop;
    logic              w_freeze;

    assign w_reset = (rst_i == RESET_ENABLE);

    // A load in execute whose destination is read by the decode instruction
    // cannot forward in time; x0 is never a real dependency.
    assign w_luh = load_e_i && RegWEn_e_i && (rd_e_i != 5'd0) &&
                   ((rs1_used_d_i && (rs1_d_i == rd_e_i)) ||
                    (rs2_used_d_i && (rs2_d_i == rd_e_i)));

    // Mealy control decode: one action per cycle chosen by state and inputs,
    // with every control output forced inactive while reset is asserted.
    always_comb begin
        w_nextState = r_state;
        w_nextWait  = r_waitCnt;
        w_setErr    = 1'b0;
        w_pcStop    = 1'b0;
        w_fdStall   = 1'b0;
        w_fdFlush   = 1'b0;
        w_deFlush   = 1'b0;
        w_deNop     = 1'b0;
        w_freeze    = 1'b0;

        case (r_state)
            PLCTRL_RUN: begin
                if (mem_req_m_i && !mem_ack_m_i) begin
                    w_freeze    = 1'b1;
                    w_pcStop    = 1'b1;
                    w_fdStall   = 1'b1;
                    w_nextState = PLCTRL_MEM_WAIT;
                    w_nextWait  = WAIT_W'(1);
                end else if (branch_taken_e_i) begin
                    w_fdFlush = 1'b1;
                    w_deFlush = 1'b1;
                end else if (w_luh) begin
                    w_pcStop  = 1'b1;
                    w_fdStall = 1'b1;
                    w_deNop   = 1'b1;
                end
            end
            PLCTRL_MEM_WAIT: begin
                if (mem_ack_m_i) begin
                    w_nextState = PLCTRL_RUN;
                    w_nextWait  = '0;
                end else if (r_waitCnt == WAIT_LIMIT) begin
                    w_freeze    = 1'b1;
                    w_pcStop    = 1'b1;
                    w_fdStall   = 1'b1;
                    w_setErr    = 1'b1;
                    w_nextState = PLCTRL_ERR;
                end else begin
                    w_freeze   = 1'b1;
                    w_pcStop   = 1'b1;
                    w_fdStall  = 1'b1;
                    w_nextWait = r_waitCnt + WAIT_W'(1);
                end
            end
            PLCTRL_ERR: begin
                w_freeze  = 1'b1;
                w_pcStop  = 1'b1;
                w_fdStall = 1'b1;
            end
            default: begin
                w_nextState = PLCTRL_RUN;
                w_nextWait  = '0;
            end
        endcase

        if (w_reset) begin
            w_pcStop  = 1'b0;
            w_fdStall = 1'b0;
            w_fdFlush = 1'b0;
            w_deFlush = 1'b0;
            w_deNop   = 1'b0;
            w_freeze  = 1'b0;
        end
    end

    // State, wait counter and the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (w_reset) begin
            r_state   <= PLCTRL_RUN;
            r_waitCnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWait;
            r_err     <= r_err | w_setErr;
        end
    end

    assign pc_stop_o  = w_pcStop  ? PC_STOP_ENABLE : ~PC_STOP_ENABLE;
    assign fd_stall_o = w_fdStall;
    assign fd_flush_o = w_fdFlush ? PLFLUSH_ENABLE : ~PLFLUSH_ENABLE;
    assign de_flush_o = w_deFlush ? PLFLUSH_ENABLE : ~PLFLUSH_ENABLE;
    assign de_nop_o   = w_deNop   ? PLFLUSH_ENABLE : ~PLFLUSH_ENABLE;
    assign freeze_o   = w_freeze;
    assign err_o      = r_err;

    perf_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stallCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_pcStop),
        .cnt_o (stall_cnt_o)
    );

    perf_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flushCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_fdFlush),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Inputs change 1 ns after the rising edge,
// outputs are sampled 1 ns later. The control outputs are checked as one
// packed vector {pc_stop, fd_stall, fd_flush, de_flush, de_nop, freeze}.
module tb_pipeline_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 16;

    localparam logic [5:0] CTRL_IDLE   = 6'b000000;
    localparam logic [5:0] CTRL_LUH    = 6'b110010;
    localparam logic [5:0] CTRL_BRANCH = 6'b001100;
    localparam logic [5:0] CTRL_FREEZE = 6'b110001;

    logic             clock = 1'b0;
    logic             rst;
    logic [4:0]       rs1, rs2, rdE;
    logic             rs1Used, rs2Used, regWe, loadE, branchE, memReq, memAck;
    logic             pcStop, fdStall, fdFlush, deFlush, deNop, freeze, errFlag;
    logic [CNT_W-1:0] stallCnt, flushCnt;
    logic [5:0]       ctrl;

    int vecCount  = 0;
    int missCount = 0;

    pipeline_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i            (clock),
        .rst_i            (rst),
        .rs1_d_i          (rs1),
        .rs2_d_i          (rs2),
        .rs1_used_d_i     (rs1Used),
        .rs2_used_d_i     (rs2Used),
        .rd_e_i           (rdE),
        .RegWEn_e_i       (regWe),
        .load_e_i         (loadE),
        .branch_taken_e_i (branchE),
        .mem_req_m_i      (memReq),
        .mem_ack_m_i      (memAck),
        .pc_stop_o        (pcStop),
        .fd_stall_o       (fdStall),
        .fd_flush_o       (fdFlush),
        .de_flush_o       (deFlush),
        .de_nop_o         (deNop),
        .freeze_o         (freeze),
        .err_o            (errFlag),
        .stall_cnt_o      (stallCnt),
        .flush_cnt_o      (flushCnt)
    );

    assign ctrl = {pcStop, fdStall, fdFlush, deFlush, deNop, freeze};

    // 10 ns core clock.
    always #5 clock = ~clock;

    // Drive one cycle's inputs and let the combinational outputs settle.
    task automatic applyStimulus(
        input logic [4:0] iRs1, input logic [4:0] iRs2,
        input logic iU1, input logic iU2,
        input logic [4:0] iRd, input logic iWe, input logic iLd,
        input logic iBr, input logic iReq, input logic iAck);
        rs1 = iRs1; rs2 = iRs2; rs1Used = iU1; rs2Used = iU2;
        rdE = iRd; regWe = iWe; loadE = iLd;
        branchE = iBr; memReq = iReq; memAck = iAck;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Idle, load-use (lw x5 / add x6,x5,x7), branch-only helpers.
    task automatic applyIdle(input logic iReq, input logic iAck);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, iReq, iAck);
    endtask

    task automatic applyLoadUse(input logic iBr, input logic iReq, input logic iAck);
        applyStimulus(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, iBr, iReq, iAck);
    endtask

    initial begin
        rst = 1'b1;
        applyIdle(1'b0, 1'b0);
        @(posedge clock);
        #1;
        tick();

        $display("[TB] reset behaviour");
        applyLoadUse(1'b1, 1'b1, 1'b0);
        checkOutput("ctrl_in_reset", 16'(ctrl), 16'(CTRL_IDLE));
        tick();
        rst = 1'b0;
        applyIdle(1'b0, 1'b0);
        checkOutput("ctrl_after_reset", 16'(ctrl), 16'(CTRL_IDLE));
        checkOutput("err_after_reset", 16'(errFlag), 16'd0);
        checkOutput("stall_after_reset", 16'(stallCnt), 16'd0);
        checkOutput("flush_after_reset", 16'(flushCnt), 16'd0);

        $display("[TB] load-use hazards");
        applyLoadUse(1'b0, 1'b0, 1'b0);
        checkOutput("luh_rs1", 16'(ctrl), 16'(CTRL_LUH));
        tick();
        applyIdle(1'b0, 1'b0);
        checkOutput("luh_cleared", 16'(ctrl), 16'(CTRL_IDLE));
        checkOutput("stall_cnt_1", 16'(stallCnt), 16'd1);
        applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("load_to_x0", 16'(ctrl), 16'(CTRL_IDLE));
        applyStimulus(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("non_load_match", 16'(ctrl), 16'(CTRL_IDLE));
        applyStimulus(5'd6, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rs2_match_unused", 16'(ctrl), 16'(CTRL_IDLE));
        applyStimulus(5'd6, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("load_no_regwe", 16'(ctrl), 16'(CTRL_IDLE));
        applyStimulus(5'd6, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("luh_rs2", 16'(ctrl), 16'(CTRL_LUH));
        tick();
        applyIdle(1'b0, 1'b0);
        checkOutput("stall_cnt_2", 16'(stallCnt), 16'd2);

        $display("[TB] branch beats load-use");
        applyLoadUse(1'b1, 1'b0, 1'b0);
        checkOutput("branch_over_luh", 16'(ctrl), 16'(CTRL_BRANCH));
        tick();
        applyIdle(1'b0, 1'b0);
        checkOutput("flush_cnt_1", 16'(flushCnt), 16'd1);
        checkOutput("stall_cnt_still_2", 16'(stallCnt), 16'd2);

        $display("[TB] memory access acked after 3 cycles");
        applyLoadUse(1'b1, 1'b1, 1'b0);
        checkOutput("mem_req_cycle", 16'(ctrl), 16'(CTRL_FREEZE));
        tick();
        applyLoadUse(1'b1, 1'b1, 1'b0);
        checkOutput("mem_wait_1", 16'(ctrl), 16'(CTRL_FREEZE));
        tick();
        applyLoadUse(1'b1, 1'b1, 1'b0);
        checkOutput("mem_wait_2", 16'(ctrl), 16'(CTRL_FREEZE));
        tick();
        applyLoadUse(1'b1, 1'b1, 1'b1);
        checkOutput("mem_ack_cycle", 16'(ctrl), 16'(CTRL_IDLE));
        tick();
        applyIdle(1'b0, 1'b0);
        checkOutput("after_ack_idle", 16'(ctrl), 16'(CTRL_IDLE));
        checkOutput("stall_cnt_5", 16'(stallCnt), 16'd5);
        checkOutput("flush_cnt_after_wait", 16'(flushCnt), 16'd1);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_back_in_run", 16'(ctrl), 16'(CTRL_BRANCH));
        tick();
        applyIdle(1'b0, 1'b0);
        checkOutput("flush_cnt_2", 16'(flushCnt), 16'd2);

        $display("[TB] zero-wait access");
        applyIdle(1'b1, 1'b1);
        checkOutput("req_ack_same_cycle", 16'(ctrl), 16'(CTRL_IDLE));
        applyLoadUse(1'b0, 1'b1, 1'b1);
        checkOutput("req_ack_with_luh", 16'(ctrl), 16'(CTRL_LUH));
        tick();
        applyIdle(1'b0, 1'b0);
        checkOutput("stall_cnt_6", 16'(stallCnt), 16'd6);

        $display("[TB] ack on the timeout cycle");
        applyIdle(1'b1, 1'b0);
        tick();
        for (int i = 1; i < MEM_TIMEOUT; i++) begin
            applyIdle(1'b1, 1'b0);
            tick();
        end
        applyIdle(1'b1, 1'b1);
        checkOutput("ack_at_timeout", 16'(ctrl), 16'(CTRL_IDLE));
        tick();
        applyIdle(1'b0, 1'b0);
        checkOutput("err_not_set_on_late_ack", 16'(errFlag), 16'd0);
        checkOutput("stall_cnt_saturated", 16'(stallCnt), 16'd15);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("run_after_late_ack", 16'(ctrl), 16'(CTRL_BRANCH));
        tick();

        $display("[TB] memory timeout");
        applyIdle(1'b1, 1'b0);
        tick();
        for (int i = 1; i < MEM_TIMEOUT; i++) begin
            applyIdle(1'b1, 1'b0);
            tick();
        end
        applyIdle(1'b1, 1'b0);
        checkOutput("timeout_cycle_ctrl", 16'(ctrl), 16'(CTRL_FREEZE));
        checkOutput("err_before_timeout", 16'(errFlag), 16'd0);
        tick();
        applyLoadUse(1'b1, 1'b1, 1'b1);
        checkOutput("err_at_17", 16'(errFlag), 16'd1);
        checkOutput("err_state_ctrl", 16'(ctrl), 16'(CTRL_FREEZE));
        tick();
        tick();
        applyIdle(1'b0, 1'b1);
        checkOutput("err_sticky", 16'(errFlag), 16'd1);
        checkOutput("err_ignores_ack", 16'(ctrl), 16'(CTRL_FREEZE));

        $display("[TB] reset out of ERR");
        rst = 1'b1;
        applyIdle(1'b0, 1'b0);
        checkOutput("ctrl_reset_in_err", 16'(ctrl), 16'(CTRL_IDLE));
        tick();
        rst = 1'b0;
        applyIdle(1'b0, 1'b0);
        checkOutput("err_cleared", 16'(errFlag), 16'd0);
        checkOutput("stall_cleared", 16'(stallCnt), 16'd0);
        checkOutput("flush_cleared", 16'(flushCnt), 16'd0);
        checkOutput("run_after_reset", 16'(ctrl), 16'(CTRL_IDLE));

        $display("[TB] stall counter saturation");
        for (int i = 0; i < 14; i++) begin
            applyLoadUse(1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("stall_cnt_14", 16'(stallCnt), 16'd14);
        for (int i = 0; i < 6; i++) begin
            applyLoadUse(1'b0, 1'b0, 1'b0);
            tick();
        end
        applyIdle(1'b0, 1'b0);
        checkOutput("stall_cnt_sat_15", 16'(stallCnt), 16'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
